imm_extend_pipe: RTL and testbench

Registered, parametrised immediate generator for the RISC-V datapath. Takes a full 32-bit instruction word, decodes its immediate format from the opcode, and assembles the immediate. Sign- or zero-extends it to XLEN bits and delivers it through a one-stage valid/ready pipeline register. It sits between instruction fetch/decode and the ALU operand mux, replacing the fixed 12-to-32 sign extender with one block that covers every immediate format.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/imm_extend_pipe_if.sv | 24 ++
 rtl/imm_extend_pipe_imm_decode.sv | 85 ++++++++
 rtl/imm_extend_pipe.sv | 58 +++++
 tb/tb_imm_extend_pipe.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: base opcodes and the immediate format codes
// carried alongside each extended immediate.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Instruction-in / immediate-out handshake bundle; slave is the immediate
// generator's view, master is the upstream/downstream environment's view.
interface imm_extend_pipe_if #(parameter int XLEN = 32);

    logic [31:0]     instr_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] imm_o;
    logic [2:0]      fmt_o;
    logic            err_o;
    logic            out_valid_o;
    logic            out_ready_i;

    modport slave (
        input  instr_i, in_valid_i, out_ready_i,
        output in_ready_o, imm_o, fmt_o, err_o, out_valid_o
    );

    modport master (
        output instr_i, in_valid_i, out_ready_i,
        input  in_ready_o, imm_o, fmt_o, err_o, out_valid_o
    );

endinterface

// File: rtl/imm_extend_pipe_imm_decode.sv
// Combinational immediate decoder: opcode -> format, raw immediate assembly and
// extension to XLEN bits. Unknown opcodes report err with a zero immediate.
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_t        o_fmt,
    output logic            o_err
);

    logic [6:0] w_opc;

    assign w_opc = i_instr[6:0];

    // Every signed format is first widened to 32 bits, then replicated to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        logic signed [XLEN-1:0] w;
        w = XLEN'(v);
        return w;
    endfunction

    function automatic logic [XLEN-1:0] zext5(input logic [4:0] v);
        return XLEN'(v);
    endfunction

    always_comb begin
        o_imm = '0;
        o_fmt = FMT_NONE;
        o_err = 1'b0;
        case (w_opc)
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: begin
                o_fmt = FMT_I;
                o_imm = sext32(32'($signed(i_instr[31:20])));
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    o_fmt = FMT_I;
                    o_imm = sext32(32'($signed(i_instr[31:20])));
                end else begin
                    o_err = 1'b1;
                end
            end
            OP_STORE: begin
                o_fmt = FMT_S;
                o_imm = sext32(32'($signed({i_instr[31:25], i_instr[11:7]})));
            end
            OP_BRANCH: begin
                o_fmt = FMT_B;
                o_imm = sext32(32'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                            i_instr[11:8], 1'b0})));
            end
            OP_LUI, OP_AUIPC: begin
                o_fmt = FMT_U;
                o_imm = sext32($signed({i_instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                o_fmt = FMT_J;
                o_imm = sext32(32'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                            i_instr[30:21], 1'b0})));
            end
            OP_SYSTEM: begin
                // CSR immediate forms carry a 5-bit unsigned uimm in the rs1 field.
                if (i_instr[14]) begin
                    o_fmt = FMT_Z;
                    o_imm = zext5(i_instr[19:15]);
                end
            end
            OP_REG: begin
                o_fmt = FMT_NONE;
            end
            OP_REG32: begin
                if (XLEN != 64) begin
                    o_err = 1'b1;
                end
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate generator with a single valid/ready output register; accepts one
// instruction per cycle and presents the decoded immediate one cycle later.
module imm_extend_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_extend_pipe_if.slave  bus
);

    logic [XLEN-1:0] w_imm_p0;
    imm_fmt_t        w_fmt_p0;
    logic            w_err_p0;
    logic            w_in_ready;
    logic            w_load;

    logic [XLEN-1:0] r_imm_p1;
    imm_fmt_t        r_fmt_p1;
    logic            r_err_p1;
    logic            r_vld_p1;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_instr (bus.instr_i),
        .o_imm   (w_imm_p0),
        .o_fmt   (w_fmt_p0),
        .o_err   (w_err_p0)
    );

    // Ready looks through the register so a drain and a load can share a cycle.
    assign w_in_ready = !r_vld_p1 || bus.out_ready_i;
    assign w_load     = bus.in_valid_i && w_in_ready;

    // p0 -> p1: decoded word captured into the output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_imm_p1 <= '0;
            r_fmt_p1 <= FMT_NONE;
            r_err_p1 <= 1'b0;
        end else if (w_load) begin
            r_vld_p1 <= 1'b1;
            r_imm_p1 <= w_imm_p0;
            r_fmt_p1 <= w_fmt_p0;
            r_err_p1 <= w_err_p0;
        end else if (bus.out_ready_i) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_vld_p1;
    assign bus.imm_o       = r_imm_p1;
    assign bus.fmt_o       = r_fmt_p1;
    assign bus.err_o       = r_err_p1;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are compared every cycle against a queue-based reference.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    imm_extend_pipe_if #(.XLEN(32)) bus32 ();
    imm_extend_pipe_if #(.XLEN(64)) bus64 ();

    assign bus32.instr_i     = instr;
    assign bus32.in_valid_i  = in_valid;
    assign bus32.out_ready_i = out_ready;
    assign bus64.instr_i     = instr;
    assign bus64.in_valid_i  = in_valid;
    assign bus64.out_ready_i = out_ready;

    imm_extend_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    imm_extend_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the format rules with plain integer arithmetic.
    function automatic void ref_decode(input logic [31:0] ins, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output logic err);
        longint v;
        int     opc;
        v   = 0;
        fmt = 3'd0;
        err = 1'b0;
        opc = int'(ins[6:0]);
        case (opc)
            'h03, 'h13, 'h67, 'h0F: begin
                fmt = 3'd1;
                v = longint'(ins[31:20]);
                if (v >= 2048) v -= 4096;
            end
            'h1B: begin
                if (xlen == 64) begin
                    fmt = 3'd1;
                    v = longint'(ins[31:20]);
                    if (v >= 2048) v -= 4096;
                end else err = 1'b1;
            end
            'h23: begin
                fmt = 3'd2;
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (v >= 2048) v -= 4096;
            end
            'h63: begin
                fmt = 3'd3;
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            'h37, 'h17: begin
                fmt = 3'd4;
                v = longint'(ins[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
            end
            'h6F: begin
                fmt = 3'd5;
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            'h73: begin
                if (ins[14]) begin
                    fmt = 3'd6;
                    v = longint'(ins[19:15]);
                end
            end
            'h33: ;
            'h3B: if (xlen != 64) err = 1'b1;
            default: err = 1'b1;
        endcase
        imm = 64'(v);
        if (xlen == 32) imm[63:32] = 32'h0;
    endfunction

    // Reference register: at most one pending word; m_last/m_zero track held data.
    logic [31:0] mq[$];
    logic [31:0] m_last = '0;
    bit          m_zero = 1'b1;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_zero <= 1'b1;
        end else if (in_valid && (mq.size() == 0 || out_ready)) begin
            if (mq.size() != 0) void'(mq.pop_front());
            mq.push_back(instr);
            m_last <= instr;
            m_zero <= 1'b0;
        end else if (mq.size() != 0 && out_ready) begin
            void'(mq.pop_front());
        end
    end

    task automatic compare_all();
        logic [63:0] e_imm32, e_imm64;
        logic [2:0]  e_fmt32, e_fmt64;
        logic        e_err32, e_err64;
        logic        e_vld, e_rdy;
        e_vld = (mq.size() != 0);
        e_rdy = !e_vld || out_ready;
        if (m_zero) begin
            e_imm32 = '0; e_fmt32 = '0; e_err32 = 1'b0;
            e_imm64 = '0; e_fmt64 = '0; e_err64 = 1'b0;
        end else begin
            ref_decode(m_last, 32, e_imm32, e_fmt32, e_err32);
            ref_decode(m_last, 64, e_imm64, e_fmt64, e_err64);
        end
        chk("vld32", 64'(bus32.out_valid_o), 64'(e_vld));
        chk("rdy32", 64'(bus32.in_ready_o), 64'(e_rdy));
        chk("imm32", 64'(bus32.imm_o), e_imm32);
        chk("fmt32", 64'(bus32.fmt_o), 64'(e_fmt32));
        chk("err32", 64'(bus32.err_o), 64'(e_err32));
        chk("vld64", 64'(bus64.out_valid_o), 64'(e_vld));
        chk("rdy64", 64'(bus64.in_ready_o), 64'(e_rdy));
        chk("imm64", bus64.imm_o, e_imm64);
        chk("fmt64", 64'(bus64.fmt_o), 64'(e_fmt64));
        chk("err64", 64'(bus64.err_o), 64'(e_err64));
    endtask

    always @(negedge clk) compare_all();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm32; logic [2:0] fmt32; logic err32;
        logic [63:0] imm64; logic [2:0] fmt64; logic err64;
    } vec_t;

    vec_t vecs[9] = '{
        '{32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0},
        '{32'hFE112E23, 64'hFFFF_FFFC, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0},
        '{32'hFE000CE3, 64'hFFFF_FFF8, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0},
        '{32'h800000B7, 64'h8000_0000, 3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0},
        '{32'h300FD073, 64'h0000_001F, 3'd6, 1'b0, 64'h0000_0000_0000_001F, 3'd6, 1'b0},
        '{32'h0000007F, 64'h0,         3'd0, 1'b1, 64'h0,                   3'd0, 1'b1},
        '{32'h002081B3, 64'h0,         3'd0, 1'b0, 64'h0,                   3'd0, 1'b0},
        '{32'hFFF0009B, 64'h0,         3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0},
        '{32'h8000006F, 64'hFFF0_0000, 3'd5, 1'b0, 64'hFFFF_FFFF_FFF0_0000, 3'd5, 1'b0}
    };

    logic [6:0] opcs[14] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h1B, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h00};

    initial begin
        logic [63:0] mi;
        logic [2:0]  mf;
        logic        me;
        bit          acc;

        rst_n = 1'b0;
        tick(); tick();
        chk("rst_vld", 64'(bus32.out_valid_o), 64'h0);
        chk("rst_imm", bus64.imm_o, 64'h0);
        rst_n = 1'b1;
        tick();

        // Directed words: each accepted alone, checked the cycle after acceptance.
        foreach (vecs[i]) begin
            ref_decode(vecs[i].ins, 32, mi, mf, me);
            chk($sformatf("model32_%0d", i), {mi[63:0]}, vecs[i].imm32);
            chk($sformatf("modelfmt32_%0d", i), 64'({mf, me}), 64'({vecs[i].fmt32, vecs[i].err32}));
            ref_decode(vecs[i].ins, 64, mi, mf, me);
            chk($sformatf("model64_%0d", i), mi, vecs[i].imm64);
            instr = vecs[i].ins; in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("dvld_%0d", i), 64'(bus32.out_valid_o), 64'h1);
            chk($sformatf("dimm32_%0d", i), 64'(bus32.imm_o), vecs[i].imm32);
            chk($sformatf("dfmt32_%0d", i), 64'(bus32.fmt_o), 64'(vecs[i].fmt32));
            chk($sformatf("derr32_%0d", i), 64'(bus32.err_o), 64'(vecs[i].err32));
            chk($sformatf("dimm64_%0d", i), bus64.imm_o, vecs[i].imm64);
            chk($sformatf("dfmt64_%0d", i), 64'(bus64.fmt_o), 64'(vecs[i].fmt64));
            chk($sformatf("derr64_%0d", i), 64'(bus64.err_o), 64'(vecs[i].err64));
            tick();
        end

        // Backpressure: addi immediates 1..4, consumer stalls 3 cycles after the first.
        instr = 32'h00100093; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; instr = 32'h00200093;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("bp_ready", 64'(bus32.in_ready_o), 64'h0);
            chk("bp_hold", 64'(bus32.imm_o), 64'h1);
            tick();
        end
        out_ready = 1'b1;
        for (int w = 2; w <= 4; w++) begin
            tick();
            chk("bp_vld", 64'(bus32.out_valid_o), 64'h1);
            chk("bp_order", 64'(bus32.imm_o), 64'(w));
            if (w < 4) instr = 32'(w + 1) << 20 | 32'h00000093;
            else in_valid = 1'b0;
        end
        tick();
        chk("bp_drain", 64'(bus32.out_valid_o), 64'h0);
        chk("bp_data_hold", 64'(bus32.imm_o), 64'h4);

        // Reset while a word is held under backpressure.
        instr = 32'hFFF00093; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("rstmid_vld", 64'(bus32.out_valid_o), 64'h0);
        chk("rstmid_imm", 64'(bus32.imm_o), 64'h0);
        chk("rstmid_fmt", 64'(bus64.fmt_o), 64'h0);
        chk("rstmid_err", 64'(bus64.err_o), 64'h0);
        rst_n = 1'b1; instr = 32'hFE112E23; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_vld", 64'(bus32.out_valid_o), 64'h1);
        chk("post_rst_imm", 64'(bus32.imm_o), 64'hFFFF_FFFC);
        tick();

        // Random stream; words are held stable until accepted.
        acc = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                instr = {$urandom()} & 32'hFFFF_FF80;
                instr[6:0] = (($urandom_range(0, 13) == 13) ? 7'($urandom())
                                                           : opcs[$urandom_range(0, 12)]);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            rst_n = ($urandom_range(0, 199) != 0);
            #1;
            acc = in_valid && bus32.in_ready_o && rst_n;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
